// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial stage with valid/ready on both sides.
// Accepts one word per handshake and emits it one bit per beat. If a new
// word is accepted on the last beat of the current one, the output stream
// has no gap. The shift register width, bit positions and the bit_idx width
// are all derived from array queries on in_data, so they follow WIDTH.
module word_serializer #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WIDTH-1:0]                          in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_bit,
  output logic                                      out_last,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] bit_idx,
  output logic                                      busy
);

  // Geometry of the data port, taken from the port declaration itself
  localparam int DATA_BITS  = $bits(in_data);
  localparam int DATA_SIZE  = $size(in_data);
  localparam int DATA_LEFT  = $left(in_data);
  localparam int DATA_RIGHT = $right(in_data);
  localparam int CW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Index of the final bit of a word
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic [DATA_LEFT:DATA_RIGHT] sreg_reg;
  logic [DATA_LEFT:DATA_RIGHT] sreg_next;
  logic [DATA_LEFT:DATA_RIGHT] sreg_shifted;
  logic [CW-1:0]               idx_reg;
  logic [CW-1:0]               idx_next;

  logic accept;
  logic beat;
  logic at_last;

  // Shift register moved one position away from the bit being emitted,
  // with a zero filled in at the far end.
  for (genvar gi = DATA_RIGHT; gi <= DATA_LEFT; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_up
      if (gi == DATA_RIGHT) begin : g_fill
        assign sreg_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sreg_shifted[gi] = sreg_reg[gi-1];
      end
    end else begin : g_down
      if (gi == DATA_LEFT) begin : g_fill
        assign sreg_shifted[gi] = 1'b0;
      end else begin : g_move
        assign sreg_shifted[gi] = sreg_reg[gi+1];
      end
    end
  end

  // Current serial bit is always the head end of the shift register
  if (MSB_FIRST) begin : g_head_msb
    assign out_bit = sreg_reg[DATA_LEFT];
  end else begin : g_head_lsb
    assign out_bit = sreg_reg[DATA_RIGHT];
  end

  assign at_last = (idx_reg == LAST_IDX);
  assign accept  = in_valid & in_ready;
  assign beat    = out_valid & out_ready;
  assign bit_idx = idx_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a word is held from accept until its last beat,
  // unless a new word is accepted on that same beat
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (beat && at_last) begin
          state_next = accept ? SHIFT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; in_ready opens in SHIFT only on the last-bit beat and
  // never looks at in_valid
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = at_last;
        in_ready  = out_ready & at_last;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, shift and count on a beat,
  // hold everything otherwise (backpressure)
  always_comb begin
    sreg_next = sreg_reg;
    idx_next  = idx_reg;
    if (accept) begin
      sreg_next = in_data;
      idx_next  = '0;
    end else if (beat) begin
      sreg_next = sreg_shifted;
      if (at_last) begin
        idx_next = '0;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  // Datapath registers; reset discards any partially sent word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_reg <= '0;
      idx_reg  <= '0;
    end else begin
      sreg_reg <= sreg_next;
      idx_reg  <= idx_next;
    end
  end

endmodule
